alu_arbiter: RTL and testbench

Shares the single combinational 4-bit `alu` between two requesters. Arbitrates round-robin, latches the granted operands and opcode into registers that drive the ALU, captures Result/Carry/Zero one cycle later and returns them with the requester ID over a valid/ready response channel. Sits directly in front of `alu`. One operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Ports: req0_*/req1_* valid/ready operand channels, alu_* registered ALU
// drive plus ALU result inputs, rsp_* valid/ready response channel, and
// gnt_cnt0/gnt_cnt1 grant counters present only with ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             e_q, e_d;

  logic             gnt0, gnt1;
  logic             acc;
  logic [2:0]       op_sel;

  // prio names the requester that wins when both are valid.
  assign gnt0 = req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = req1_valid && (!req0_valid || prio_q);

  // rst_n gating keeps ready low combinationally during reset.
  assign req0_ready = rst_n && (state_q == IDLE) && gnt0;
  assign req1_ready = rst_n && (state_q == IDLE) && gnt1;
  assign acc        = req0_ready || req1_ready;
  assign op_sel     = req1_ready ? req1_op : req0_op;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    c_d     = c_q;
    z_d     = z_q;
    e_d     = e_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          id_d   = req1_ready;
          prio_d = !req1_ready;
          a_d    = req1_ready ? req1_a : req0_a;
          b_d    = req1_ready ? req1_b : req0_b;
          op_d   = op_sel;
          if (op_sel > 3'd4) begin
            // Illegal opcode skips the ALU cycle entirely.
            res_d   = '0;
            c_d     = 1'b0;
            z_d     = 1'b0;
            e_d     = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        res_d   = alu_result;
        c_d     = alu_carry;
        z_d     = alu_zero;
        e_d     = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      e_q     <= e_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_result  = res_q;
  assign rsp_carry   = c_q;
  assign rsp_zero    = z_q;
  assign rsp_err     = e_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Saturating: stop at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (req1_ready && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural 4-bit ALU attached.
// Expected responses are queued at stimulus time and popped on output.
module tb_alu_arbiter;

  typedef logic [7:0] rsp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_control;
  logic [3:0] alu_result;
  logic       alu_carry, alu_zero;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_err;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int   errs = 0;
  int   checks = 0;
  rsp_t sbq[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // Behavioural ALU; SUB carry reports a borrow.
  always_comb begin
    logic [4:0] s;
    s = 5'd0;
    alu_carry = 1'b0;
    case (alu_control)
      3'b000: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = s[4];
      end
      3'b001: begin
        s = {1'b0, alu_a - alu_b};
        alu_carry = (alu_a < alu_b);
      end
      3'b010: s = {1'b0, alu_a & alu_b};
      3'b011: s = {1'b0, alu_a | alu_b};
      3'b100: s = {1'b0, alu_a ^ alu_b};
      default: s = 5'd0;
    endcase
    alu_result = s[3:0];
    alu_zero = (s[3:0] == 4'd0);
  end

  function automatic rsp_t cur_rsp();
    return {rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err};
  endfunction

  task automatic send(input bit id, input logic [3:0] a,
                      input logic [3:0] b, input logic [2:0] op,
                      output bit ok);
    ok = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic collect(output rsp_t got, output bit ok);
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) begin
        got = cur_rsp();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [22:0] v;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    v = {alu_a, alu_b, alu_control, rsp_valid, rsp_id, rsp_result,
         rsp_carry, rsp_zero, rsp_err, req0_ready, req1_ready};
    checks++;
    if (v !== '0) begin
      errs++;
      $display("FAIL reset_outputs got=%h want=0", v);
    end
`ifdef ALU_ARB_STATS_EN
    checks++;
    if ({gnt_cnt0, gnt_cnt1} !== 16'd0) begin
      errs++;
      $display("FAIL reset_cnt got=%h want=0", {gnt_cnt0, gnt_cnt1});
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errs++;
      $display("FAIL reset_grant got=%b want=10",
               {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single_add();
    rsp_t e;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0001;
    req0_op = 3'b000;
    sbq.push_back({1'b0, 4'b0100, 1'b0, 1'b0, 1'b0});
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errs++;
      $display("FAIL add_ready got=%b want=10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_control} !== {4'd3, 4'd1, 3'd0}) begin
      errs++;
      $display("FAIL add_alu_regs got=%h want=%h",
               {alu_a, alu_b, alu_control}, {4'd3, 4'd1, 3'd0});
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL add_early_valid got=%b want=0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errs++;
      $display("FAIL add_latency got=%b want=1", rsp_valid);
    end
    e = sbq.pop_front();
    checks++;
    if (cur_rsp() !== e) begin
      errs++;
      $display("FAIL add_rsp got=%h want=%h", cur_rsp(), e);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL add_release got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_carry_zero();
    rsp_t got, e;
    bit ok;
    sbq.push_back({1'b1, 4'b0110, 1'b1, 1'b0, 1'b0});
    sbq.push_back({1'b1, 4'b0000, 1'b0, 1'b1, 1'b0});
    for (int k = 0; k < 2; k++) begin
      if (k == 0) send(1'b1, 4'b1100, 4'b1010, 3'b000, ok);
      else        send(1'b1, 4'b1010, 4'b1010, 3'b100, ok);
      collect(got, ok);
      checks++;
      if (!ok) begin
        errs++;
        $display("FAIL cz_timeout%0d got=no_rsp want=rsp", k);
      end
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        errs++;
        $display("FAIL cz_rsp%0d got=%h want=%h", k, got, e);
      end
    end
  endtask

  task automatic test_contention();
    rsp_t got, e;
    bit ok;
    req0_a = 4'b0100; req0_b = 4'b0010; req0_op = 3'b001;
    req1_a = 4'b1100; req1_b = 4'b1010; req1_op = 3'b010;
    for (int k = 0; k < 2; k++) begin
      sbq.push_back({1'b0, 4'b0010, 1'b0, 1'b0, 1'b0});
      sbq.push_back({1'b1, 4'b1000, 1'b0, 1'b0, 1'b0});
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      collect(got, ok);
      checks++;
      if (!ok) begin
        errs++;
        $display("FAIL cont_timeout%0d got=no_rsp want=rsp", k);
      end
      e = sbq.pop_front();
      checks++;
      if (got !== e) begin
        errs++;
        $display("FAIL cont_rsp%0d got=%h want=%h", k, got, e);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_illegal();
    rsp_t got, e;
    bit ok;
    sbq.push_back({1'b0, 4'b0000, 1'b0, 1'b0, 1'b1});
    send(1'b0, 4'b0101, 4'b0011, 3'b111, ok);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errs++;
      $display("FAIL ill_latency got=%b want=1", rsp_valid);
    end
    checks++;
    if (alu_control !== 3'b111) begin
      errs++;
      $display("FAIL ill_alu_ctrl got=%b want=111", alu_control);
    end
`ifdef ALU_ARB_STATS_EN
    checks++;
    if ({gnt_cnt0, gnt_cnt1} !== {8'd4, 8'd4}) begin
      errs++;
      $display("FAIL ill_cnt got=%0d/%0d want=4/4", gnt_cnt0, gnt_cnt1);
    end
`endif
    collect(got, ok);
    e = sbq.pop_front();
    checks++;
    if (got !== e) begin
      errs++;
      $display("FAIL ill_rsp got=%h want=%h", got, e);
    end
  endtask

  task automatic test_back_pressure();
    rsp_t got, e;
    bit ok;
    rsp_ready = 1'b0;
    req0_a = 4'b0100; req0_b = 4'b0010; req0_op = 3'b001;
    req1_a = 4'b0001; req1_b = 4'b0010; req1_op = 3'b000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    sbq.push_back({1'b1, 4'b0011, 1'b0, 1'b0, 1'b0});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL bp_timeout got=no_rsp want=rsp");
    end
    e = sbq.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({cur_rsp(), rsp_valid, req0_ready, req1_ready} !==
          {e, 1'b1, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL bp_hold%0d got=%h want=%h", i,
                 {cur_rsp(), rsp_valid, req0_ready, req1_ready},
                 {e, 3'b100});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errs++;
      $display("FAIL bp_hs_ready got=%b want=00", {req0_ready, req1_ready});
    end
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errs++;
      $display("FAIL bp_next_grant got=%b want=10",
               {req0_ready, req1_ready});
    end
    req1_valid = 1'b0;
    sbq.push_back({1'b0, 4'b0010, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    req0_valid = 1'b0;
    collect(got, ok);
    e = sbq.pop_front();
    checks++;
    if (got !== e) begin
      errs++;
      $display("FAIL bp_after_rsp got=%h want=%h", got, e);
    end
  endtask

  task automatic test_reset_mid();
    rsp_t got, e;
    bit ok;
    logic [20:0] v;
    send(1'b0, 4'b0011, 4'b0001, 3'b000, ok);
    rst_n = 1'b0;
    #1;
    v = {alu_a, alu_b, alu_control, rsp_valid, rsp_id, rsp_result,
         rsp_carry, rsp_zero, rsp_err};
    checks++;
    if (v !== '0) begin
      errs++;
      $display("FAIL rst_mid_outputs got=%h want=0", v);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errs++;
        $display("FAIL rst_mid_rsp%0d got=%b want=0", i, rsp_valid);
      end
    end
    req0_a = 4'b0010; req0_b = 4'b0010; req0_op = 3'b000;
    req1_a = 4'b0001; req1_b = 4'b0100; req1_op = 3'b011;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errs++;
      $display("FAIL rst_mid_grant got=%b want=10",
               {req0_ready, req1_ready});
    end
    sbq.push_back({1'b0, 4'b0100, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    collect(got, ok);
    e = sbq.pop_front();
    checks++;
    if (got !== e) begin
      errs++;
      $display("FAIL rst_mid_rsp got=%h want=%h", got, e);
    end
    checks++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL sb_empty got=%0d want=0", sbq.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    test_reset();
    test_single_add();
    test_carry_zero();
    test_contention();
    test_illegal();
    test_back_pressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
